vpifo_task_dispatcher: RTL and testbench

- Sequenced front-end for the virtualised BMW PIFO SRAM array (PIFO_SRAM_TOP-style bank of RPU_NUM RPUs, RPU 0 = root tree).
- Buffers incoming pushes and fans each one out to the root RPU and to the owning sub-tree RPU.
- Runs the two-phase pop (root pop, then sub-tree pop) as a handshaked FSM instead of a same-cycle combinational chain.
- Tracks per-tree occupancy so pops to an empty scheduler are rejected cleanly, and generalises tree-to-RPU mapping to any TREE_NUM/RPU_NUM.

---
 rtl/vpifo_task_dispatcher.sv | 222 ++++++++++++++++++++++
 tb/tb_vpifo_task_dispatcher.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vpifo_task_dispatcher.sv
// Sequenced push/pop front-end for a bank of PIFO RPUs (RPU 0 holds the root tree).
// Pushes are queued and fanned out to root + owning RPU; pops run root-then-subtree via a handshaked FSM.
module vpifo_task_dispatcher #(
  parameter int PTW      = 16,
  parameter int MTW      = 8,
  parameter int TREE_NUM = 8,
  parameter int RPU_NUM  = 4,
  parameter int CTW      = 10,
  parameter int IQ_DEPTH = 4,
  localparam int DW  = MTW + PTW,
  localparam int TNB = $clog2(TREE_NUM),
  localparam int RNB = $clog2(RPU_NUM)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push_valid,
  output logic                   o_push_ready,
  input  logic [TNB-1:0]         i_push_tree_id,
  input  logic [PTW-1:0]         i_push_priority,
  input  logic [DW-1:0]          i_push_data,
  output logic                   o_push_err,
  input  logic                   i_pop_req,
  output logic                   o_pop_ready,
  output logic                   o_pop_valid,
  output logic [TNB-1:0]         o_pop_tree_id,
  output logic [DW-1:0]          o_pop_data,
  output logic                   o_pop_empty,
  output logic [RPU_NUM-1:0]     o_rpu_push,
  output logic [RPU_NUM-1:0]     o_rpu_pop,
  output logic [RPU_NUM*TNB-1:0] o_rpu_tree_id,
  output logic [RPU_NUM*DW-1:0]  o_rpu_data,
  input  logic [RPU_NUM-1:0]     i_rpu_full,
  input  logic                   i_root_pop_valid,
  input  logic [DW-1:0]          i_root_pop_data,
  input  logic                   i_sub_pop_valid,
  input  logic [TNB-1:0]         i_sub_pop_tree_id,
  input  logic [DW-1:0]          i_sub_pop_data
);

  localparam int QAW = $clog2(IQ_DEPTH);
  localparam int QW  = TNB + PTW + DW;
  localparam int TTW = CTW + TNB;

  typedef enum logic [1:0] {IDLE, ROOT_WAIT, SUB_WAIT} pop_state_e;

  // Tree 0 is the root, so sub-trees spread over RPUs 1..RPU_NUM-1.
  function automatic logic [RNB-1:0] rpu_of(input logic [TNB-1:0] t);
    logic [TNB:0] v;
    v = (TNB+1)'(t) % (TNB+1)'(RPU_NUM - 1);
    v = v + (TNB+1)'(1);
    return v[RNB-1:0];
  endfunction

  // ingress queue
  logic [QW-1:0]  iq_mem [IQ_DEPTH];
  logic [QAW-1:0] wr_ptr, rd_ptr;
  logic [QAW:0]   iq_cnt;
  logic           enq, deq, push_acc, push_bad;
  logic [QW-1:0]  head;
  logic [TNB-1:0] head_tree;
  logic [PTW-1:0] head_prio;
  logic [DW-1:0]  head_data;
  logic [RNB-1:0] head_rpu;
  logic [DW-1:0]  root_word;

  // counters and FSM
  logic [CTW-1:0]      occ [TREE_NUM];
  logic [TREE_NUM-1:0] occ_up, occ_dn;
  logic [TTW-1:0]      total_q;
  pop_state_e          state_q, state_d;
  logic                root_issue, sub_issue, empty_hit, pop_done;
  logic [TNB-1:0]      sub_tree;
  logic [RNB-1:0]      sub_rpu;
  logic                dispatch, pop_conflict;
  logic                unused_root_bits;

  logic [RPU_NUM-1:0]          rpu_push_d, rpu_pop_d;
  logic [RPU_NUM-1:0][TNB-1:0] rpu_tid_d;
  logic [RPU_NUM-1:0][DW-1:0]  rpu_data_d;

  assign o_push_ready = !i_rst && (iq_cnt != (QAW+1)'(IQ_DEPTH));
  assign o_pop_ready  = !i_rst && (state_q == IDLE);
  assign push_acc     = i_push_valid && o_push_ready;
  assign push_bad     = push_acc && (i_push_tree_id == '0);
  assign enq          = push_acc && (i_push_tree_id != '0);

  assign head      = iq_mem[rd_ptr];
  assign head_tree = head[QW-1 -: TNB];
  assign head_prio = head[DW +: PTW];
  assign head_data = head[DW-1:0];
  assign head_rpu  = rpu_of(head_tree);

  always_comb begin
    root_word = '0;
    root_word[DW-1 -: TNB] = head_tree;
    root_word[PTW-1:0]     = head_prio;
  end

  assign sub_tree         = i_root_pop_data[DW-1 -: TNB];
  assign sub_rpu          = rpu_of(sub_tree);
  assign unused_root_bits = ^i_root_pop_data[DW-TNB-1:0];

  // A root pop always collides with a dispatch (both use RPU 0); pops win.
  assign pop_conflict = root_issue || (sub_issue && (sub_rpu == head_rpu));
  assign dispatch     = (iq_cnt != '0) && !i_rpu_full[0] && !i_rpu_full[head_rpu]
                      && (occ[head_tree] != '1) && !pop_conflict;
  assign deq          = dispatch;

  always_ff @(posedge i_clk) begin
    if (enq) iq_mem[wr_ptr] <= {i_push_tree_id, i_push_priority, i_push_data};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      iq_cnt <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      if (enq && !deq)      iq_cnt <= iq_cnt + 1'b1;
      else if (deq && !enq) iq_cnt <= iq_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    root_issue = 1'b0;
    sub_issue  = 1'b0;
    empty_hit  = 1'b0;
    pop_done   = 1'b0;
    case (state_q)
      IDLE: if (i_pop_req) begin
        if (total_q == '0) empty_hit = 1'b1;
        else begin
          root_issue = 1'b1;
          state_d    = ROOT_WAIT;
        end
      end
      ROOT_WAIT: if (i_root_pop_valid) begin
        sub_issue = 1'b1;
        state_d   = SUB_WAIT;
      end
      SUB_WAIT: if (i_sub_pop_valid) begin
        pop_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < TREE_NUM; i++) begin
      occ_up[i] = dispatch && (head_tree == TNB'(i));
      occ_dn[i] = pop_done && (i_sub_pop_tree_id == TNB'(i)) && (occ[i] != '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < TREE_NUM; i++) occ[i] <= '0;
      total_q <= '0;
    end else begin
      for (int i = 0; i < TREE_NUM; i++) begin
        if (occ_up[i] && !occ_dn[i])      occ[i] <= occ[i] + 1'b1;
        else if (occ_dn[i] && !occ_up[i]) occ[i] <= occ[i] - 1'b1;
      end
      if (dispatch && !(pop_done && total_q != '0))      total_q <= total_q + 1'b1;
      else if (!dispatch && pop_done && total_q != '0)   total_q <= total_q - 1'b1;
    end
  end

  // Idle RPU lanes present tree 0 and all-ones data.
  always_comb begin
    rpu_push_d = '0;
    rpu_pop_d  = '0;
    rpu_tid_d  = '0;
    rpu_data_d = '1;
    if (dispatch) begin
      rpu_push_d[0]        = 1'b1;
      rpu_push_d[head_rpu] = 1'b1;
      rpu_data_d[0]        = root_word;
      rpu_data_d[head_rpu] = head_data;
      rpu_tid_d[head_rpu]  = head_tree;
    end
    if (root_issue) rpu_pop_d[0] = 1'b1;
    if (sub_issue) begin
      rpu_pop_d[sub_rpu] = 1'b1;
      rpu_tid_d[sub_rpu] = sub_tree;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rpu_push    <= '0;
      o_rpu_pop     <= '0;
      o_rpu_tree_id <= '0;
      o_rpu_data    <= '1;
      o_pop_valid   <= 1'b0;
      o_pop_tree_id <= '0;
      o_pop_data    <= '1;
      o_pop_empty   <= 1'b0;
      o_push_err    <= 1'b0;
    end else begin
      o_rpu_push    <= rpu_push_d;
      o_rpu_pop     <= rpu_pop_d;
      o_rpu_tree_id <= rpu_tid_d;
      o_rpu_data    <= rpu_data_d;
      o_pop_valid   <= pop_done;
      o_pop_tree_id <= pop_done ? i_sub_pop_tree_id : '0;
      o_pop_data    <= pop_done ? i_sub_pop_data : '1;
      o_pop_empty   <= empty_hit;
      o_push_err    <= push_bad;
    end
  end

endmodule

// File: tb/tb_vpifo_task_dispatcher.sv
// Directed bench for vpifo_task_dispatcher: reset, push fan-out, pop sequence, empty pop, backpressure.
module tb_vpifo_task_dispatcher;
  localparam int PTW = 16, MTW = 8, TREE_NUM = 8, RPU_NUM = 4, CTW = 10, IQ_DEPTH = 4;
  localparam int DW = MTW + PTW, TNB = 3;

  logic                   i_clk = 1'b0;
  logic                   i_rst, i_push_valid, i_pop_req;
  logic                   o_push_ready, o_push_err, o_pop_ready, o_pop_valid, o_pop_empty;
  logic [TNB-1:0]         i_push_tree_id, o_pop_tree_id, i_sub_pop_tree_id;
  logic [PTW-1:0]         i_push_priority;
  logic [DW-1:0]          i_push_data, o_pop_data, i_root_pop_data, i_sub_pop_data;
  logic [RPU_NUM-1:0]     o_rpu_push, o_rpu_pop, i_rpu_full;
  logic [RPU_NUM*TNB-1:0] o_rpu_tree_id;
  logic [RPU_NUM*DW-1:0]  o_rpu_data;
  logic                   i_root_pop_valid, i_sub_pop_valid;

  vpifo_task_dispatcher #(
    .PTW(PTW), .MTW(MTW), .TREE_NUM(TREE_NUM), .RPU_NUM(RPU_NUM), .CTW(CTW), .IQ_DEPTH(IQ_DEPTH)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_push_valid(i_push_valid), .o_push_ready(o_push_ready), .i_push_tree_id(i_push_tree_id),
    .i_push_priority(i_push_priority), .i_push_data(i_push_data), .o_push_err(o_push_err),
    .i_pop_req(i_pop_req), .o_pop_ready(o_pop_ready), .o_pop_valid(o_pop_valid),
    .o_pop_tree_id(o_pop_tree_id), .o_pop_data(o_pop_data), .o_pop_empty(o_pop_empty),
    .o_rpu_push(o_rpu_push), .o_rpu_pop(o_rpu_pop), .o_rpu_tree_id(o_rpu_tree_id),
    .o_rpu_data(o_rpu_data), .i_rpu_full(i_rpu_full),
    .i_root_pop_valid(i_root_pop_valid), .i_root_pop_data(i_root_pop_data),
    .i_sub_pop_valid(i_sub_pop_valid), .i_sub_pop_tree_id(i_sub_pop_tree_id),
    .i_sub_pop_data(i_sub_pop_data)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1; i_push_valid = 1'b1; i_push_tree_id = 3'd3; i_push_priority = 16'h0001;
    i_push_data = 24'h000001; i_pop_req = 1'b0; i_rpu_full = '0;
    i_root_pop_valid = 1'b0; i_root_pop_data = '0; i_sub_pop_valid = 1'b0;
    i_sub_pop_tree_id = '0; i_sub_pop_data = '0;

    // reset with a push held active
    step(); step();
    chk("rst_push_strobe", o_rpu_push, 4'b0000);
    chk("rst_push_ready", o_push_ready, 1'b0);
    chk("rst_pop_ready", o_pop_ready, 1'b0);
    chk("rst_pop_data", o_pop_data, 24'hFFFFFF);
    chk("rst_rpu_data", o_rpu_data, {RPU_NUM*DW{1'b1}});
    chk("rst_rpu_tid", o_rpu_tree_id, '0);
    i_rst = 1'b0; i_push_valid = 1'b0;
    step();
    chk("post_rst_push_ready", o_push_ready, 1'b1);
    chk("post_rst_pop_ready", o_pop_ready, 1'b1);
    chk("post_rst_no_strobe", o_rpu_push, 4'b0000);

    // pop on empty scheduler
    i_pop_req = 1'b1;
    step();
    i_pop_req = 1'b0;
    chk("empty_pulse", o_pop_empty, 1'b1);
    chk("empty_no_rpu_pop", o_rpu_pop, 4'b0000);
    step();
    chk("empty_pulse_end", o_pop_empty, 1'b0);
    chk("empty_stay_idle", o_pop_ready, 1'b1);

    // push tree 5 -> rpu(5) = 1 + 5%3 = 3
    i_push_valid = 1'b1; i_push_tree_id = 3'd5; i_push_priority = 16'h0010; i_push_data = 24'h123456;
    step();
    i_push_valid = 1'b0;
    chk("t5_not_yet", o_rpu_push, 4'b0000);
    step();
    chk("t5_push_strobe", o_rpu_push, 4'b1001);
    chk("t5_root_data", o_rpu_data[0*DW +: DW], 24'hA00010);
    chk("t5_sub_data", o_rpu_data[3*DW +: DW], 24'h123456);
    chk("t5_sub_tid", o_rpu_tree_id[3*TNB +: TNB], 3'd5);
    chk("t5_root_tid", o_rpu_tree_id[0*TNB +: TNB], 3'd0);
    chk("t5_idle_lane_data", o_rpu_data[1*DW +: DW], 24'hFFFFFF);
    step();
    chk("t5_strobe_end", o_rpu_push, 4'b0000);
    chk("t5_data_idle", o_rpu_data[3*DW +: DW], 24'hFFFFFF);

    // push tree 0 is dropped
    i_push_valid = 1'b1; i_push_tree_id = 3'd0;
    step();
    i_push_valid = 1'b0;
    chk("t0_err", o_push_err, 1'b1);
    step();
    chk("t0_err_end", o_push_err, 1'b0);
    chk("t0_no_strobe", o_rpu_push, 4'b0000);

    // result valid in IDLE is ignored
    i_sub_pop_valid = 1'b1; i_sub_pop_tree_id = 3'd5; i_sub_pop_data = 24'h777777;
    step();
    i_sub_pop_valid = 1'b0;
    chk("stray_sub_valid", o_pop_valid, 1'b0);

    // full pop sequence
    i_pop_req = 1'b1;
    step();
    i_pop_req = 1'b0;
    chk("pop_root_strobe", o_rpu_pop, 4'b0001);
    chk("pop_busy", o_pop_ready, 1'b0);
    i_root_pop_valid = 1'b1; i_root_pop_data = 24'hA0FFFF;
    step();
    i_root_pop_valid = 1'b0;
    chk("pop_sub_strobe", o_rpu_pop, 4'b1000);
    chk("pop_sub_tid", o_rpu_tree_id[3*TNB +: TNB], 3'd5);
    step();
    chk("pop_sub_strobe_end", o_rpu_pop, 4'b0000);
    chk("pop_wait_no_valid", o_pop_valid, 1'b0);
    i_sub_pop_valid = 1'b1; i_sub_pop_tree_id = 3'd5; i_sub_pop_data = 24'h00ABCD;
    step();
    i_sub_pop_valid = 1'b0;
    chk("pop_valid", o_pop_valid, 1'b1);
    chk("pop_tree", o_pop_tree_id, 3'd5);
    chk("pop_data", o_pop_data, 24'h00ABCD);
    step();
    chk("pop_valid_end", o_pop_valid, 1'b0);
    chk("pop_data_idle", o_pop_data, 24'hFFFFFF);
    chk("pop_back_idle", o_pop_ready, 1'b1);
    i_pop_req = 1'b1;
    step();
    i_pop_req = 1'b0;
    chk("pop_total_zero", o_pop_empty, 1'b1);

    // backpressure: rpu(2) = 3 held full, queue fills at four
    i_rpu_full = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      i_push_valid = 1'b1; i_push_tree_id = 3'd2;
      i_push_priority = 16'(k); i_push_data = 24'(k + 1);
      chk($sformatf("bp_ready_%0d", k), o_push_ready, (k < 4) ? 1'b1 : 1'b0);
      step();
    end
    i_push_valid = 1'b0;
    step();
    chk("bp_stalled", o_rpu_push, 4'b0000);
    i_rpu_full = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("bp_strobe_%0d", k), o_rpu_push, 4'b1001);
      chk($sformatf("bp_data_%0d", k), o_rpu_data[3*DW +: DW], 24'(k + 1));
      chk($sformatf("bp_root_%0d", k), o_rpu_data[0*DW +: DW], 24'h400000 | 24'(k));
    end
    step();
    chk("bp_drained", o_rpu_push, 4'b0000);

    // reset mid-pop abandons the sequence and clears counters
    i_pop_req = 1'b1;
    step();
    i_pop_req = 1'b0;
    chk("mid_root_strobe", o_rpu_pop, 4'b0001);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    i_root_pop_valid = 1'b1; i_root_pop_data = 24'h40FFFF;
    step();
    i_root_pop_valid = 1'b0;
    chk("mid_late_root_ignored", o_rpu_pop, 4'b0000);
    i_pop_req = 1'b1;
    step();
    i_pop_req = 1'b0;
    chk("mid_counters_cleared", o_pop_empty, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
